// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//
// Shares one SRAM-like memory port between an instruction-fetch requester
// (port I) and a load/store requester (port D). Address-phase requests are
// arbitrated with D priority plus a starvation guard for I. A grant is held
// stable by a lock register until downstream accepts it. Every accepted
// request is recorded in an in-order tracking queue, so each returning
// response is routed to its owner. Fetch responses cancelled by a pipeline
// flush are dropped.
//
// Ports:
//   clk, reset                         clock, async active-high reset
//   i_req/i_wr/i_size/i_addr/i_wstrb/i_wdata   I request inputs
//   i_addr_ok/i_data_ok/i_rdata                I handshake / response outputs
//   d_*                                 same set for port D
//   flush                               discard outstanding and same-cycle I fetches
//   m_req/m_wr/m_size/m_addr/m_wstrb/m_wdata   downstream request outputs
//   m_addr_ok/m_data_ok/m_rdata                downstream handshake / response inputs
//   busy                                queue non-empty or lock held
module mem_req_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,

    input  logic        flush,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    logic            lock_valid;
    owner_t          lock_owner;
    logic [2:0]      streak;
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    owner_t          q_owner   [DEPTH];
    logic            q_discard [DEPTH];

    owner_t          owner;
    owner_t          head_owner;
    logic            head_discard;
    logic            accept;
    logic            pop;

    // Ownership: a pending lock pins the grant; otherwise D wins unless I has
    // waited through STARVE_LIMIT consecutive D accepts. The full check uses
    // the registered count, so a pop in the same cycle does not open a slot.
    always_comb begin
        owner = OWNER_I;
        if (lock_valid) begin
            owner = lock_owner;
        end else if (d_req && !(i_req && streak == STARVE_MAX)) begin
            owner = OWNER_D;
        end

        m_req  = (lock_valid || i_req || d_req) && (count < FULL_COUNT);
        accept = m_req && m_addr_ok;

        m_wr    = (owner == OWNER_D) ? d_wr    : i_wr;
        m_size  = (owner == OWNER_D) ? d_size  : i_size;
        m_addr  = (owner == OWNER_D) ? d_addr  : i_addr;
        m_wstrb = (owner == OWNER_D) ? d_wstrb : i_wstrb;
        m_wdata = (owner == OWNER_D) ? d_wdata : i_wdata;

        i_addr_ok = accept && (owner == OWNER_I);
        d_addr_ok = accept && (owner == OWNER_D);
    end

    // Response routing from the queue head. A response with an empty queue is
    // spurious and neither pops nor reaches a requester. A flush in the same
    // cycle also cancels an I response that is popping right now.
    always_comb begin
        head_owner   = q_owner[rd_ptr];
        head_discard = q_discard[rd_ptr];
        pop          = m_data_ok && (count != '0);
        i_data_ok    = pop && (head_owner == OWNER_I) && !head_discard && !flush;
        d_data_ok    = pop && (head_owner == OWNER_D);
        i_rdata      = m_rdata;
        d_rdata      = m_rdata;
        busy         = lock_valid || (count != '0);
    end

    // Lock register: a request shown but not accepted keeps its owner until
    // downstream takes it, so the address phase never changes mid-handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_owner <= OWNER_I;
        end else if (accept) begin
            lock_valid <= 1'b0;
        end else if (m_req) begin
            lock_valid <= 1'b1;
            lock_owner <= owner;
        end
    end

    // Starvation streak: counts D accepts while I keeps asking; any I accept
    // or any cycle without an I request starts the count over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= 3'd0;
        end else if (!i_req || i_addr_ok) begin
            streak <= 3'd0;
        end else if (d_addr_ok && streak < STARVE_MAX) begin
            streak <= streak + 3'd1;
        end
    end

    // Tracking queue. Flush marks every I entry as discarded; stale slots
    // outside the valid window may also be marked, which is harmless because
    // a push rewrites both fields of its slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_owner[i]   <= OWNER_I;
                q_discard[i] <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_owner[i] == OWNER_I) begin
                        q_discard[i] <= 1'b1;
                    end
                end
            end
            if (accept) begin
                q_owner[wr_ptr]   <= owner;
                q_discard[wr_ptr] <= (owner == OWNER_I) && flush;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//
// Bench for mem_req_arbiter. A queue-based reference model tracks the owner
// and discard state of outstanding requests; outputs are compared against it
// on every falling clock edge, and directed scenarios add literal checks.
module tb_mem_req_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        i_req, i_wr;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        flush;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 = I, 1 = D
    int mq_owner[$];
    bit mq_disc[$];
    int acc_log[$];
    bit md_lock_v = 0;
    int md_lock_o = 0;
    int md_streak = 0;

    // Expected values derived from the model and the current inputs
    int e_own;
    bit e_mreq, e_acc, e_pop, e_iok, e_dok, e_busy;

    mem_req_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
        .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .flush(flush),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Hold the current inputs for n rising edges, then step just past the edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // What the arbiter must do this cycle, from the rules alone.
    task automatic computeExpect();
        int sz;
        sz = mq_owner.size();
        if (md_lock_v)                                          e_own = md_lock_o;
        else if (d_req && !(i_req && md_streak == STARVE_LIMIT)) e_own = 1;
        else                                                    e_own = 0;
        e_mreq = (md_lock_v || i_req || d_req) && (sz < DEPTH);
        e_acc  = e_mreq && m_addr_ok;
        e_pop  = m_data_ok && (sz > 0);
        e_iok  = e_pop && (mq_owner[0] == 0) && !mq_disc[0] && !flush;
        e_dok  = e_pop && (mq_owner[0] == 1);
        e_busy = md_lock_v || (sz != 0);
    endtask

    // Model advance on each clock edge (or asynchronously on reset).
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq_owner.delete();
                mq_disc.delete();
                md_lock_v = 0;
                md_lock_o = 0;
                md_streak = 0;
            end else begin
                computeExpect();
                if (flush) begin
                    foreach (mq_owner[k]) if (mq_owner[k] == 0) mq_disc[k] = 1;
                end
                if (e_pop) begin
                    void'(mq_owner.pop_front());
                    void'(mq_disc.pop_front());
                end
                if (e_acc) begin
                    mq_owner.push_back(e_own);
                    mq_disc.push_back((e_own == 0) && flush);
                    acc_log.push_back(e_own);
                end
                if (e_acc)       md_lock_v = 0;
                else if (e_mreq) begin
                    md_lock_v = 1;
                    md_lock_o = e_own;
                end
                if (!i_req || (e_acc && e_own == 0)) md_streak = 0;
                else if (e_acc && e_own == 1 && md_streak < STARVE_LIMIT) md_streak++;
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            computeExpect();
            checkOutput("m_req",     m_req,     e_mreq);
            checkOutput("busy",      busy,      e_busy);
            checkOutput("i_addr_ok", i_addr_ok, e_acc && e_own == 0);
            checkOutput("d_addr_ok", d_addr_ok, e_acc && e_own == 1);
            checkOutput("i_data_ok", i_data_ok, e_iok);
            checkOutput("d_data_ok", d_data_ok, e_dok);
            checkOutput("i_rdata",   i_rdata,   m_rdata);
            checkOutput("d_rdata",   d_rdata,   m_rdata);
            if (e_mreq) begin
                checkOutput("m_addr",  m_addr,  e_own ? d_addr  : i_addr);
                checkOutput("m_wr",    m_wr,    e_own ? d_wr    : i_wr);
                checkOutput("m_size",  m_size,  e_own ? d_size  : i_size);
                checkOutput("m_wstrb", m_wstrb, e_own ? d_wstrb : i_wstrb);
                checkOutput("m_wdata", m_wdata, e_own ? d_wdata : i_wdata);
            end
        end
    end

    // Directed scenarios with literal expectations.
    initial begin
        logic [7:0] order_bits;

        reset = 1'b1;
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 0; i_wstrb = 4'hf; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 0; d_wstrb = 4'hf; d_wdata = 0;
        flush = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(1);
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_m_req", m_req, 0);

        $display("[TB] single D load");
        d_req = 1; d_addr = 32'h1000; m_addr_ok = 1;
        #2;
        checkOutput("load_d_addr_ok", d_addr_ok, 1);
        checkOutput("load_m_addr", m_addr, 32'h1000);
        applyStimulus(1);
        d_req = 0; m_addr_ok = 0;
        applyStimulus(2);
        m_data_ok = 1; m_rdata = 32'hDEADBEEF;
        #2;
        checkOutput("load_d_data_ok", d_data_ok, 1);
        checkOutput("load_d_rdata", d_rdata, 32'hDEADBEEF);
        checkOutput("load_i_data_ok", i_data_ok, 0);
        applyStimulus(1);
        m_data_ok = 0;

        $display("[TB] starvation guard");
        acc_log.delete();
        i_req = 1; i_addr = 32'h0100;
        d_req = 1; d_addr = 32'h2000; d_wr = 1; d_wdata = 32'h55; d_wstrb = 4'h3; d_size = 2'd1;
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h1234;
        applyStimulus(8);
        i_req = 0; d_req = 0; m_addr_ok = 0;
        applyStimulus(1);
        m_data_ok = 0; d_wr = 0; d_wstrb = 4'hf; d_size = 2'd2;
        order_bits = '0;
        for (int k = 0; k < 8; k++) if (k < acc_log.size()) order_bits[k] = acc_log[k][0];
        checkOutput("starve_count", acc_log.size(), 8);
        checkOutput("starve_order", {24'd0, order_bits}, 32'h77);

        $display("[TB] lock holds grant");
        acc_log.delete();
        i_req = 1; i_addr = 32'h2000; m_addr_ok = 0;
        #2;
        checkOutput("lock_addr_c0", m_addr, 32'h2000);
        for (int c = 1; c < 4; c++) begin
            applyStimulus(1);
            d_req = 1; d_addr = 32'h3000;
            #2;
            checkOutput("lock_addr", m_addr, 32'h2000);
            checkOutput("lock_d_addr_ok", d_addr_ok, 0);
        end
        applyStimulus(1);
        m_addr_ok = 1;
        #2;
        checkOutput("lock_i_accept", i_addr_ok, 1);
        applyStimulus(1);
        i_req = 0;
        #2;
        checkOutput("lock_d_accept", d_addr_ok, 1);
        applyStimulus(1);
        d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        applyStimulus(2);
        m_data_ok = 0;
        checkOutput("lock_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            checkOutput("lock_first", acc_log[0], 0);
            checkOutput("lock_second", acc_log[1], 1);
        end

        $display("[TB] full queue");
        d_req = 1; d_addr = 32'h4000; m_addr_ok = 1;
        applyStimulus(4);
        m_data_ok = 1;
        #2;
        checkOutput("full_m_req", m_req, 0);
        checkOutput("full_busy", busy, 1);
        checkOutput("full_d_addr_ok", d_addr_ok, 0);
        applyStimulus(1);
        m_data_ok = 0;
        #2;
        checkOutput("after_pop_m_req", m_req, 1);
        checkOutput("after_pop_accept", d_addr_ok, 1);
        applyStimulus(1);
        d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        applyStimulus(4);
        m_data_ok = 0;
        #2;
        checkOutput("full_drained_busy", busy, 0);

        $display("[TB] flush");
        i_req = 1; i_addr = 32'h5000; m_addr_ok = 1;
        applyStimulus(1);
        i_req = 0; d_req = 1; d_addr = 32'h6000;
        applyStimulus(1);
        d_req = 0; i_req = 1; i_addr = 32'h5004;
        applyStimulus(1);
        i_req = 0; m_addr_ok = 0; flush = 1;
        applyStimulus(1);
        flush = 0; m_data_ok = 1; m_rdata = 32'hCAFE0001;
        #2;
        checkOutput("flush_r0_i", i_data_ok, 0);
        checkOutput("flush_r0_d", d_data_ok, 0);
        applyStimulus(1);
        #2;
        checkOutput("flush_r1_i", i_data_ok, 0);
        checkOutput("flush_r1_d", d_data_ok, 1);
        applyStimulus(1);
        #2;
        checkOutput("flush_r2_i", i_data_ok, 0);
        checkOutput("flush_r2_d", d_data_ok, 0);
        applyStimulus(1);
        m_data_ok = 0;
        #2;
        checkOutput("flush_busy", busy, 0);

        $display("[TB] spurious response and reset");
        applyStimulus(1);
        m_data_ok = 1;
        #2;
        checkOutput("spur_i", i_data_ok, 0);
        checkOutput("spur_d", d_data_ok, 0);
        checkOutput("spur_busy", busy, 0);
        applyStimulus(1);
        m_data_ok = 0; d_req = 1; d_addr = 32'h7000; m_addr_ok = 1;
        applyStimulus(2);
        d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_d_data_ok", d_data_ok, 0);
        applyStimulus(1);
        reset = 1'b0;
        #2;
        checkOutput("post_rst_d_data_ok", d_data_ok, 0);
        checkOutput("post_rst_busy", busy, 0);
        applyStimulus(1);
        m_data_ok = 0;
        applyStimulus(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
